pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/arc_pkg.sv | 5 +
 rtl/pc_gen_if.sv | 22 ++
 rtl/pc_gen.sv | 75 +++++++
 tb/tb_pc_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/arc_pkg.sv
// arc_pkg: shared fetch-side types and constants
package arc_pkg;
  localparam int unsigned INSTR_BYTES = 4;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} fsm_state_e;
endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: control, instruction-memory and fetch-stage signals of pc_gen
interface pc_gen_if;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_PC;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        o_valid;
  logic [31:0] o_data_Instr;
  logic [31:0] o_addr_PC;
  modport master (
    input  i_stall, i_redirect, i_redirect_PC, i_imem_gnt, i_imem_rvalid, i_imem_rdata,
    output o_imem_req, o_imem_addr, o_valid, o_data_Instr, o_addr_PC
  );
  modport slave (
    output i_stall, i_redirect, i_redirect_PC, i_imem_gnt, i_imem_rvalid, i_imem_rdata,
    input  o_imem_req, o_imem_addr, o_valid, o_data_Instr, o_addr_PC
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program counter and single-outstanding instruction fetch FSM
module pc_gen
  import arc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input logic       i_clk,
  input logic       i_rst,
  pc_gen_if.master  bus
);
  fsm_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, addr_q, addr_d, tgt;
  logic        kill_q, kill_d;
  assign tgt = {bus.i_redirect_PC[31:2], 2'b00};
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus.i_redirect) pc_d = tgt;
        if (bus.i_imem_gnt) begin
          state_d = WAIT;
          kill_d  = bus.i_redirect;
        end
      end
      WAIT: begin
        if (bus.i_redirect) pc_d = tgt;
        // a response is stale if a redirect arrived while it was in flight or alongside it
        if (bus.i_imem_rvalid) begin
          kill_d = 1'b0;
          if (kill_q || bus.i_redirect) state_d = REQ;
          else begin
            state_d = VALID;
            instr_d = bus.i_imem_rdata;
            addr_d  = pc_q;
          end
        end else if (bus.i_redirect) kill_d = 1'b1;
      end
      VALID: begin
        if (bus.i_redirect) begin
          pc_d    = tgt;
          state_d = REQ;
        end else if (!bus.i_stall) begin
          pc_d    = pc_q + 32'(INSTR_BYTES);
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      kill_q  <= 1'b0;
      instr_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
    end
  end
  assign bus.o_imem_req   = (state_q == REQ);
  assign bus.o_valid      = (state_q == VALID);
  assign bus.o_imem_addr  = pc_q;
  assign bus.o_data_Instr = instr_q;
  assign bus.o_addr_PC    = addr_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard-driven bench for pc_gen fetch, stall, redirect, wrap and reset
module tb_pc_gen;
  localparam logic [31:0] RV = 32'hBFC0_0000;
  typedef struct {logic [31:0] a; logic [31:0] d;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  pc_gen_if bus();
  pc_gen #(.RESET_VECTOR(RV)) dut (.i_clk(clk), .i_rst(rst), .bus(bus.master));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int gd, input logic st);
    exp_t e;
    int n = 0;
    while (!bus.o_imem_req && n < 20) begin
      step();
      n++;
    end
    total++;
    if (bus.o_imem_req !== 1'b1) begin bad++; $display("FAIL req_timeout got=%b want=1", bus.o_imem_req); end
    total++;
    if (bus.o_imem_addr !== a) begin bad++; $display("FAIL req_addr got=%h want=%h", bus.o_imem_addr, a); end
    for (int i = 0; i < gd; i++) begin
      bus.i_imem_rvalid = 1'b1;
      bus.i_imem_rdata  = 32'hDEAD_BEEF;
      step();
      bus.i_imem_rvalid = 1'b0;
      total++;
      if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== a || bus.o_valid !== 1'b0) begin
        bad++;
        $display("FAIL req_hold got req=%b addr=%h valid=%b want req=1 addr=%h valid=0", bus.o_imem_req, bus.o_imem_addr, bus.o_valid, a);
      end
    end
    bus.i_imem_gnt = 1'b1;
    step();
    bus.i_imem_gnt = 1'b0;
    total++;
    if (bus.o_imem_req !== 1'b0) begin bad++; $display("FAIL wait_req got=%b want=0", bus.o_imem_req); end
    bus.i_imem_rvalid = 1'b1;
    bus.i_imem_rdata  = d;
    bus.i_stall       = st;
    sb.push_back('{a, d});
    step();
    bus.i_imem_rvalid = 1'b0;
    total++;
    if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL valid got=%b want=1", bus.o_valid); end
    e = sb.pop_front();
    total++;
    if (bus.o_addr_PC !== e.a || bus.o_data_Instr !== e.d) begin
      bad++;
      $display("FAIL deliver got pc=%h instr=%h want pc=%h instr=%h", bus.o_addr_PC, bus.o_data_Instr, e.a, e.d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_imem_req !== 1'b0 || bus.o_imem_addr !== RV || bus.o_data_Instr !== 32'h0 || bus.o_addr_PC !== 32'h0) begin
      bad++;
      $display("FAIL reset got valid=%b req=%b addr=%h instr=%h pc=%h", bus.o_valid, bus.o_imem_req, bus.o_imem_addr, bus.o_data_Instr, bus.o_addr_PC);
    end
    rst = 1'b0;
    total++;
    if (bus.o_imem_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%b want=0", bus.o_imem_req); end
    step();
    total++;
    if (bus.o_imem_req !== 1'b1) begin bad++; $display("FAIL idle_len got=%b want=1", bus.o_imem_req); end
  endtask

  task automatic test_basic();
    fetch(RV, 32'h1111_0000, 0, 1'b0);
    step();
    total++;
    if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL valid_pulse got=%b want=0", bus.o_valid); end
    fetch(RV + 32'd4, 32'h1111_0004, 2, 1'b0);
  endtask

  task automatic test_stall();
    fetch(RV + 32'd8, 32'h2408_0001, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (bus.o_valid !== 1'b1 || bus.o_data_Instr !== 32'h2408_0001 || bus.o_addr_PC !== RV + 32'd8 || bus.o_imem_req !== 1'b0 || bus.o_imem_addr !== RV + 32'd8) begin
        bad++;
        $display("FAIL stall_hold got valid=%b instr=%h pc=%h req=%b addr=%h", bus.o_valid, bus.o_data_Instr, bus.o_addr_PC, bus.o_imem_req, bus.o_imem_addr);
      end
    end
    bus.i_stall = 1'b0;
    step();
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== RV + 32'd12) begin
      bad++;
      $display("FAIL stall_release got valid=%b req=%b addr=%h want 0 1 %h", bus.o_valid, bus.o_imem_req, bus.o_imem_addr, RV + 32'd12);
    end
  endtask

  task automatic test_redirect_wait();
    bus.i_imem_gnt = 1'b1;
    step();
    bus.i_imem_gnt = 1'b0;
    bus.i_redirect = 1'b1;
    bus.i_redirect_PC = 32'h0000_1003;
    step();
    bus.i_redirect = 1'b0;
    total++;
    if (bus.o_imem_req !== 1'b0 || bus.o_imem_addr !== 32'h0000_1000) begin
      bad++;
      $display("FAIL rw_wait got req=%b addr=%h want 0 00001000", bus.o_imem_req, bus.o_imem_addr);
    end
    step();
    bus.i_imem_rvalid = 1'b1;
    bus.i_imem_rdata  = 32'hBAD0_0001;
    step();
    bus.i_imem_rvalid = 1'b0;
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h0000_1000) begin
      bad++;
      $display("FAIL rw_discard got valid=%b req=%b addr=%h want 0 1 00001000", bus.o_valid, bus.o_imem_req, bus.o_imem_addr);
    end
    fetch(32'h0000_1000, 32'h3333_1000, 0, 1'b0);
  endtask

  task automatic test_redirect_gnt();
    step();
    total++;
    if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h0000_1004) begin
      bad++;
      $display("FAIL rg_req got req=%b addr=%h want 1 00001004", bus.o_imem_req, bus.o_imem_addr);
    end
    bus.i_imem_gnt = 1'b1;
    bus.i_redirect = 1'b1;
    bus.i_redirect_PC = 32'h0000_2000;
    step();
    bus.i_imem_gnt = 1'b0;
    bus.i_redirect = 1'b0;
    total++;
    if (bus.o_imem_req !== 1'b0 || bus.o_imem_addr !== 32'h0000_2000) begin
      bad++;
      $display("FAIL rg_wait got req=%b addr=%h want 0 00002000", bus.o_imem_req, bus.o_imem_addr);
    end
    bus.i_imem_rvalid = 1'b1;
    bus.i_imem_rdata  = 32'hBAD0_0002;
    step();
    bus.i_imem_rvalid = 1'b0;
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h0000_2000) begin
      bad++;
      $display("FAIL rg_discard got valid=%b req=%b addr=%h want 0 1 00002000", bus.o_valid, bus.o_imem_req, bus.o_imem_addr);
    end
    fetch(32'h0000_2000, 32'h4444_2000, 0, 1'b0);
  endtask

  task automatic test_wrap();
    bus.i_stall = 1'b1;
    bus.i_redirect = 1'b1;
    bus.i_redirect_PC = 32'hFFFF_FFFE;
    step();
    bus.i_redirect = 1'b0;
    bus.i_stall = 1'b0;
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL rv_valid got valid=%b req=%b addr=%h want 0 1 fffffffc", bus.o_valid, bus.o_imem_req, bus.o_imem_addr);
    end
    fetch(32'hFFFF_FFFC, 32'h5555_FFFC, 0, 1'b0);
    step();
    total++;
    if (bus.o_imem_addr !== 32'h0000_0000) begin bad++; $display("FAIL wrap got=%h want=00000000", bus.o_imem_addr); end
    fetch(32'h0000_0000, 32'h6666_0000, 0, 1'b0);
  endtask

  task automatic test_reset_wait();
    step();
    bus.i_imem_gnt = 1'b1;
    step();
    rst = 1'b1;
    bus.i_imem_rvalid = 1'b1;
    bus.i_imem_rdata  = 32'hBAD0_0003;
    bus.i_redirect = 1'b1;
    bus.i_redirect_PC = 32'h0000_3000;
    step();
    bus.i_imem_gnt = 1'b0;
    bus.i_imem_rvalid = 1'b0;
    bus.i_redirect = 1'b0;
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_imem_req !== 1'b0 || bus.o_imem_addr !== RV || bus.o_data_Instr !== 32'h0 || bus.o_addr_PC !== 32'h0) begin
      bad++;
      $display("FAIL rst_wait got valid=%b req=%b addr=%h instr=%h pc=%h", bus.o_valid, bus.o_imem_req, bus.o_imem_addr, bus.o_data_Instr, bus.o_addr_PC);
    end
    rst = 1'b0;
    step();
    total++;
    if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== RV) begin
      bad++;
      $display("FAIL rst_restart got req=%b addr=%h want 1 %h", bus.o_imem_req, bus.o_imem_addr, RV);
    end
    fetch(RV, 32'h7777_0000, 1, 1'b0);
  endtask

  initial begin
    bus.i_stall = 1'b0;
    bus.i_redirect = 1'b0;
    bus.i_redirect_PC = 32'h0;
    bus.i_imem_gnt = 1'b0;
    bus.i_imem_rvalid = 1'b0;
    bus.i_imem_rdata = 32'h0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_gnt();
    test_wrap();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
